// File: rtl/expr_pkg.sv
// Shared types and constants for the expression evaluator.
// State encoding, character classes, operator tag, ASCII codes.
package expr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPND,
    OPER,
    ERR,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CC_DIG,
    CC_ADD,
    CC_MUL,
    CC_EQ,
    CC_OTH
  } cls_t;

  typedef enum logic {
    OP_ADD,
    OP_MUL
  } op_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2b;
  localparam logic [7:0] CH_MUL = 8'h2a;
  localparam logic [7:0] CH_EQ  = 8'h3d;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier.
// ch -> cls (DIG/ADD/MUL/EQ/OTH), dig = ch - '0' (meaningful for DIG).
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output cls_t       cls,
  output logic [3:0] dig
);

  logic [7:0] off;

  assign off = ch - CH_0;
  assign dig = off[3:0];

  always_comb begin
    cls = CC_OTH;
    unique case (1'b1)
      (ch >= CH_0 && ch <= CH_9): cls = CC_DIG;
      (ch == CH_ADD):             cls = CC_ADD;
      (ch == CH_MUL):             cls = CC_MUL;
      (ch == CH_EQ):              cls = CC_EQ;
      default:                    cls = CC_OTH;
    endcase
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for digit ((+|*) digit)* '=' with * over +.
// Ports: clk, clr (async low), in_* char handshake, res_* result handshake, busy.
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_LEN = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         res_err,
  output logic         busy
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        st;
  op_t           op;
  logic [W-1:0]  sum;
  logic [W-1:0]  term;
  logic [LW-1:0] len;
  logic [LW-1:0] len_nx;
  cls_t          cls;
  logic [3:0]    dig;
  logic [W-1:0]  dw;
  logic          ovf;

  expr_char_class u_cc (
    .ch  (in_data),
    .cls (cls),
    .dig (dig)
  );

  assign dw = W'(dig);

  // len saturates so a long run of junk in ERR cannot wrap it.
  assign len_nx = (len == LW'(MAX_LEN)) ? len : len + 1'b1;
  assign ovf    = (cls != CC_EQ) && (len_nx == LW'(MAX_LEN));

  assign in_ready = (st != DONE);
  assign busy     = (st != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st        <= IDLE;
      op        <= OP_ADD;
      sum       <= '0;
      term      <= '0;
      len       <= '0;
      res_valid <= 1'b0;
      result    <= '0;
      res_err   <= 1'b0;
    end else if (st == DONE) begin
      if (res_ready) begin
        st        <= IDLE;
        op        <= OP_ADD;
        sum       <= '0;
        term      <= '0;
        len       <= '0;
        res_valid <= 1'b0;
      end
    end else if (in_valid) begin
      len <= len_nx;
      unique case (st)
        IDLE: begin
          unique case (cls)
            CC_DIG: begin
              term <= dw;
              sum  <= '0;
              st   <= OPND;
            end
            CC_EQ: begin
              st        <= DONE;
              res_valid <= 1'b1;
              result    <= '0;
              res_err   <= 1'b1;
            end
            default: st <= ERR;
          endcase
        end
        OPND: begin
          unique case (cls)
            CC_ADD: begin
              sum <= sum + term;
              op  <= OP_ADD;
              st  <= OPER;
            end
            CC_MUL: begin
              op <= OP_MUL;
              st <= OPER;
            end
            CC_EQ: begin
              st        <= DONE;
              res_valid <= 1'b1;
              result    <= sum + term;
              res_err   <= 1'b0;
            end
            default: st <= ERR;
          endcase
        end
        OPER: begin
          unique case (cls)
            CC_DIG: begin
              term <= (op == OP_ADD) ? dw : term * dw;
              st   <= OPND;
            end
            CC_EQ: begin
              st        <= DONE;
              res_valid <= 1'b1;
              result    <= '0;
              res_err   <= 1'b1;
            end
            default: st <= ERR;
          endcase
        end
        ERR: begin
          if (cls == CC_EQ) begin
            st        <= DONE;
            res_valid <= 1'b1;
            result    <= '0;
            res_err   <= 1'b1;
          end
        end
        default: st <= ERR;
      endcase
      // Length limit overrides any non-'=' transition.
      if (ovf) st <= ERR;
    end
  end

endmodule
